// File: rtl/playdriver.sv
// PDM playback driver: streams the sample memory MSB-first to the audio amplifier.
// Optional PLAYDRIVER_LOOP_EN: wrap to word 0 while playEN is held high at the end of the last word.
module playdriver #(
  parameter int CLK_DIV = 50,
  parameter int ADDR_W  = 10
) (
  input  logic              big_clk,
  input  logic              reset,
  input  logic              playEN,
  input  logic [31:0]       rd_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] address,
  output logic              audPWM,
  output logic              audSD,
  output logic              flag_play,
  output logic              done
);
  localparam int                TW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0]     TICK_LAST = TW'(CLK_DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH1, S_FETCH2, S_PLAY} state_t;

  state_t              state_q, state_d;
  logic [31:0]         shift_q, shift_d;
  logic [31:0]         shadow_q, shadow_d;
  logic [4:0]          bitcnt_q, bitcnt_d;
  logic [TW-1:0]       tickcnt_q, tickcnt_d;
  logic                last_q, last_d;
  logic                playen_q, playen_d;
  logic                rd_en_q, rd_en_d;
  logic                rd_pend_q, rd_pend_d;
  logic [ADDR_W-1:0]   address_q, address_d;
  logic                pwm_q, pwm_d;
  logic                sd_q, sd_d;
  logic                done_q, done_d;
  logic                start, tick, keep_going, prefetch_ok;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    shadow_d  = shadow_q;
    bitcnt_d  = bitcnt_q;
    tickcnt_d = tickcnt_q;
    last_d    = last_q;
    address_d = address_q;
    rd_en_d   = 1'b0;
    done_d    = 1'b0;
    playen_d  = playEN;
    rd_pend_d = rd_en_q;
    start     = playEN & ~playen_q;
    tick      = (state_q == S_PLAY) && (tickcnt_q == TICK_LAST);
`ifdef PLAYDRIVER_LOOP_EN
    keep_going  = ~last_q | playEN;
    prefetch_ok = 1'b1;
`else
    keep_going  = ~last_q;
    prefetch_ok = (address_q != ADDR_LAST);
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_FETCH1;
          rd_en_d   = 1'b1;
          address_d = '0;
        end
      end
      S_FETCH1: begin
        state_d   = S_FETCH2;
        rd_en_d   = 1'b1;
        address_d = ADDR_W'(1);
      end
      S_FETCH2: begin
        state_d   = S_PLAY;
        shift_d   = rd_data;
        bitcnt_d  = '0;
        tickcnt_d = '0;
        last_d    = 1'b0;
      end
      S_PLAY: begin
        if (rd_pend_q) shadow_d = rd_data;
        if (tick) begin
          tickcnt_d = '0;
          if (bitcnt_q != 5'd31) begin
            shift_d  = {shift_q[30:0], 1'b0};
            bitcnt_d = bitcnt_q + 5'd1;
          end else if (keep_going) begin
            // Word boundary: the prefetched word in shadow always arrives long before this point
            shift_d  = shadow_q;
            bitcnt_d = '0;
            last_d   = (address_q == ADDR_LAST);
            done_d   = last_q;
            if (prefetch_ok) begin
              rd_en_d   = 1'b1;
              address_d = address_q + ADDR_W'(1);
            end
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            last_d  = 1'b0;
          end
        end else begin
          tickcnt_d = tickcnt_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    pwm_d = (state_d == S_PLAY) & shift_d[31];
    sd_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge big_clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      shift_q   <= '0;
      shadow_q  <= '0;
      bitcnt_q  <= '0;
      tickcnt_q <= '0;
      last_q    <= 1'b0;
      playen_q  <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_pend_q <= 1'b0;
      address_q <= '0;
      pwm_q     <= 1'b0;
      sd_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      shadow_q  <= shadow_d;
      bitcnt_q  <= bitcnt_d;
      tickcnt_q <= tickcnt_d;
      last_q    <= last_d;
      playen_q  <= playen_d;
      rd_en_q   <= rd_en_d;
      rd_pend_q <= rd_pend_d;
      address_q <= address_d;
      pwm_q     <= pwm_d;
      sd_q      <= sd_d;
      done_q    <= done_d;
    end
  end

  assign rd_en     = rd_en_q;
  assign address   = address_q;
  assign audPWM    = pwm_q;
  assign audSD     = sd_q;
  assign flag_play = sd_q;
  assign done      = done_q;
endmodule

// File: tb/tb_playdriver.sv
// Bench for playdriver with a small geometry (CLK_DIV=4, 8 words) and a position-based playback model.
module tb_playdriver;
  localparam int D  = 4;
  localparam int AW = 3;
  localparam int N  = 1 << AW;
  localparam int WB = 32 * D;
  localparam int T  = N * WB;
`ifdef PLAYDRIVER_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  localparam int END_ADDR = LOOP ? 0 : N - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          playEN = 1'b0;
  logic [31:0]   rd_data = '0;
  logic          rd_en, audPWM, audSD, flag_play, done;
  logic [AW-1:0] address;
  logic [31:0]   mem [N];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rd_count = 0;
  int done_count = 0;

  // model state: pos is the cycle index relative to the first PLAY cycle of the current pass
  logic m_active = 1'b0;
  int   m_pos = 0;
  int   m_pass = 0;
  int   m_held = 0;
  logic pe_prev = 1'b0;
  logic m_start;

  playdriver #(.CLK_DIV(D), .ADDR_W(AW)) dut (
    .big_clk(clk), .reset(reset), .playEN(playEN), .rd_data(rd_data),
    .rd_en(rd_en), .address(address), .audPWM(audPWM), .audSD(audSD),
    .flag_play(flag_play), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_en) rd_data <= mem[address];
  end

  assign m_start = playEN & ~pe_prev;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active <= 1'b0;
      m_pos    <= 0;
      m_pass   <= 0;
      m_held   <= 0;
      pe_prev  <= 1'b0;
    end else begin
      pe_prev <= playEN;
      if ((!m_active || m_pos == T) && m_start) begin
        m_active <= 1'b1;
        m_pos    <= -2;
        m_pass   <= 0;
      end else if (m_active) begin
        if (m_pos == T) begin
          m_active <= 1'b0;
          m_held   <= END_ADDR;
        end else if (LOOP && m_pos == T - 1 && playEN) begin
          m_pos  <= 0;
          m_pass <= m_pass + 1;
        end else begin
          m_pos <= m_pos + 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic e_rd, e_pwm, e_sd, e_done;
    int   e_addr, w, b;
    e_rd = 0; e_pwm = 0; e_sd = 0; e_done = 0; e_addr = m_held; w = 0; b = 0;
    if (m_active) begin
      if (m_pos == -2) begin
        e_rd = 1; e_addr = 0; e_sd = 1;
      end else if (m_pos == -1) begin
        e_rd = 1; e_addr = 1; e_sd = 1;
      end else if (m_pos < T) begin
        w      = m_pos / WB;
        b      = 31 - (m_pos % WB) / D;
        e_pwm  = mem[w][b];
        e_sd   = 1;
        e_done = (m_pass > 0) && (m_pos == 0);
        e_rd   = (m_pos % WB == 0) &&
                 ((w >= 1 && w <= N - 2) || (LOOP && (w == N - 1 || (w == 0 && m_pass > 0))));
        e_addr = LOOP ? (w + 1) % N : ((w + 1 < N - 1) ? w + 1 : N - 1);
      end else begin
        e_done = 1; e_addr = END_ADDR;
      end
    end
    check("rd_en", 32'(rd_en), 32'(e_rd));
    check("address", 32'(address), 32'(e_addr));
    check("audPWM", 32'(audPWM), 32'(e_pwm));
    check("audSD", 32'(audSD), 32'(e_sd));
    check("flag_play", 32'(flag_play), 32'(e_sd));
    check("done", 32'(done), 32'(e_done));
    if (rd_en) rd_count++;
    if (done) done_count++;
  end

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while ((m_active || audSD) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", 32'(n < limit), 32'd1);
  endtask

  initial begin
    logic [7:0] a5;
    int f1_cyc, n;
    a5 = 8'hA5;
    mem[0] = 32'hA5A5_0000;
    for (int i = 1; i < N; i++) mem[i] = 32'(i);

    #1;
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_address", 32'(address), 32'd0);
    check("rst_audPWM", 32'(audPWM), 32'd0);
    check("rst_audSD", 32'(audSD), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // run 1: A5A5_0000 then address-valued words, with a second playEN edge mid-playback
    repeat (2) @(posedge clk);
    rd_count = 0;
    done_count = 0;
    #2 playEN = 1'b1;
    @(posedge clk);
    @(negedge clk);
    f1_cyc = cyc;
    check("f1_rd_en", 32'(rd_en), 32'd1);
    check("f1_address", 32'(address), 32'd0);
    repeat (2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      check("a5_bit", 32'(audPWM), 32'(a5[7 - i]));
      repeat (D) @(negedge clk);
    end
    @(posedge clk); #2 playEN = 1'b0;
    repeat (300) @(posedge clk);
    #2 playEN = 1'b1;
    repeat (5) @(posedge clk);
    #2 playEN = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(done), 32'd1);
    check("done_latency", 32'(cyc - f1_cyc), 32'(2 + T));
    check("done_audSD", 32'(audSD), 32'd0);
    @(negedge clk);
    check("rd_en_pulses", 32'(rd_count), 32'(N));
    check("done_pulses", 32'(done_count), 32'd1);

    // run 2: boundary patterns, reset in the middle of word 5, then restart from address 0
    mem[0] = 32'hFFFF_FFFF; mem[1] = 32'h0000_0000; mem[2] = 32'h8000_0001;
    mem[3] = 32'h7FFF_FFFE; mem[4] = 32'hDEAD_BEEF; mem[5] = 32'h1234_5678;
    mem[6] = 32'hFFFF_FFFF; mem[7] = 32'hC0FF_EE01;
    @(posedge clk); #2 playEN = 1'b1;
    repeat (2 + 5 * WB + 50) @(posedge clk);
    #2 playEN = 1'b0;
    reset = 1'b1;
    #1;
    check("midrst_rd_en", 32'(rd_en), 32'd0);
    check("midrst_address", 32'(address), 32'd0);
    check("midrst_audPWM", 32'(audPWM), 32'd0);
    check("midrst_audSD", 32'(audSD), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    @(posedge clk); #2 playEN = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("restart_rd_en", 32'(rd_en), 32'd1);
    check("restart_address", 32'(address), 32'd0);
    @(posedge clk); #2 playEN = 1'b0;
    wait_idle(3000);

    // run 3: playEN held across the end of the last word, then dropped
    @(posedge clk);
    done_count = 0;
    #2 playEN = 1'b1;
    repeat (T + 200) @(posedge clk);
    #2 playEN = 1'b0;
    wait_idle(4000);
    check("hold_done_pulses", 32'(done_count), LOOP ? 32'd2 : 32'd1);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
